spi_master_datapath: RTL and testbench

//  Shift/count datapath of the SPI master; consumes the controller FSM's

---
 rtl/spi_master_datapath_if.sv | 31 +++
 rtl/spi_master_datapath.sv | 85 ++++++++
 tb/tb_spi_master_datapath.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_datapath_if.sv
// Bundle of controller/SCLK-generator controls and serial/receive datapath signals
// for the SPI master shift/count datapath.
interface spi_master_datapath_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_load_register;
  logic                  i_shift_enable;
  logic                  i_counter_enable;
  logic                  i_leading;
  logic                  i_trailling;
  logic                  i_CPHA;
  logic                  i_lsb_first;
  logic [DATA_WIDTH-1:0] i_tx_data;
  logic                  i_miso;
  logic                  o_mosi;
  logic                  o_counter_done;
  logic [DATA_WIDTH-1:0] o_rx_data;
  logic                  o_rx_valid;

  modport master (
    output i_load_register, i_shift_enable, i_counter_enable, i_leading, i_trailling,
           i_CPHA, i_lsb_first, i_tx_data, i_miso,
    input  o_mosi, o_counter_done, o_rx_data, o_rx_valid
  );

  modport slave (
    input  i_load_register, i_shift_enable, i_counter_enable, i_leading, i_trailling,
           i_CPHA, i_lsb_first, i_tx_data, i_miso,
    output o_mosi, o_counter_done, o_rx_data, o_rx_valid
  );
endinterface

// File: rtl/spi_master_datapath.sv
// SPI master shift/count datapath: serialises a word onto MOSI, deserialises MISO,
// counts bits on trailing SCLK edges and strobes rx-valid when a word completes.
module spi_master_datapath #(
  parameter  int DATA_WIDTH = 8,
  localparam int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input logic                  i_clk,
  input logic                  i_reset,
  spi_master_datapath_if.slave bus
);

  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] tx_next;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [DATA_WIDTH-1:0] rx_data;
  logic [CNT_WIDTH-1:0]  bit_cnt;
  logic                  mosi;
  logic                  mosi_next;
  logic                  rx_valid;
  logic                  lead;
  logic                  trail;
  logic                  shift_ev;
  logic                  sample_ev;
  logic                  count_ev;
  logic                  last_bit;
  logic                  wrap;

  always_comb begin
    // Coincident strobes are treated as no edge at all.
    lead      = bus.i_leading & ~bus.i_trailling;
    trail     = bus.i_trailling & ~bus.i_leading;
    shift_ev  = bus.i_shift_enable & (bus.i_CPHA ? lead : trail);
    sample_ev = bus.i_shift_enable & (bus.i_CPHA ? trail : lead);
    count_ev  = trail & bus.i_counter_enable;
    last_bit  = (bit_cnt == CNT_WIDTH'(DATA_WIDTH - 1));
    wrap      = count_ev & last_bit;

    tx_next   = bus.i_lsb_first ? (tx_sr >> 1) : (tx_sr << 1);
    mosi_next = bus.i_lsb_first ? tx_next[0] : tx_next[DATA_WIDTH-1];

    rx_next = rx_sr;
    if (sample_ev) begin
      rx_next = bus.i_lsb_first ? {bus.i_miso, rx_sr[DATA_WIDTH-1:1]}
                                : {rx_sr[DATA_WIDTH-2:0], bus.i_miso};
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      tx_sr    <= '0;
      rx_sr    <= '0;
      rx_data  <= '0;
      bit_cnt  <= '0;
      mosi     <= 1'b0;
      rx_valid <= 1'b0;
    end else if (bus.i_load_register) begin
      tx_sr    <= bus.i_tx_data;
      mosi     <= bus.i_lsb_first ? bus.i_tx_data[0] : bus.i_tx_data[DATA_WIDTH-1];
      rx_sr    <= '0;
      bit_cnt  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= wrap;
      rx_sr    <= rx_next;
      if (shift_ev) begin
        tx_sr <= tx_next;
        mosi  <= mosi_next;
      end
      if (count_ev) begin
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end
      // rx_next already holds a bit sampled on this same trailing edge (CPHA=1).
      if (wrap) begin
        rx_data <= rx_next;
      end
    end
  end

  assign bus.o_mosi         = mosi;
  assign bus.o_counter_done = last_bit;
  assign bus.o_rx_data      = rx_data;
  assign bus.o_rx_valid     = rx_valid;

endmodule

// File: tb/tb_spi_master_datapath.sv
// Self-checking bench for spi_master_datapath: directed vector table, hand-written
// reset/load-priority sequences and randomized words against a bit-index model.
module tb_spi_master_datapath;

  localparam int DW = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  spi_master_datapath_if #(.DATA_WIDTH(DW)) bus ();

  spi_master_datapath #(.DATA_WIDTH(DW)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] tx;
    logic [DW-1:0] slave;
    logic          cpha;
    logic          lsb;
    logic          exp_first;
    logic [DW-1:0] exp_rx;
  } vec_t;

  // Reference: bit k of a transfer is simply indexed out of the word.
  function automatic logic bit_at(input logic [DW-1:0] w, input int unsigned k, input logic lsb);
    return lsb ? w[k] : w[DW-1-k];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic lead, input logic trail);
    bus.i_leading   = lead;
    bus.i_trailling = trail;
    tick();
    bus.i_leading   = 1'b0;
    bus.i_trailling = 1'b0;
  endtask

  task automatic gap(input logic rnd);
    int unsigned n;
    n = rnd ? $urandom_range(2, 0) : 0;
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic load_word(input logic [DW-1:0] tx, input logic cpha, input logic lsb);
    bus.i_CPHA            = cpha;
    bus.i_lsb_first       = lsb;
    bus.i_tx_data         = tx;
    bus.i_load_register   = 1'b1;
    tick();
    bus.i_load_register   = 1'b0;
    check("load_mosi", 32'(bus.o_mosi), 32'(bit_at(tx, 0, lsb)));
    check("load_cnt_done", 32'(bus.o_counter_done), 32'd0);
  endtask

  // Drives all SCLK edges of one word; tx must already be loaded.
  task automatic run_bits(input logic [DW-1:0] tx, input logic [DW-1:0] slave,
                          input logic [DW-1:0] exp_rx, input logic cpha,
                          input logic lsb, input logic glitch, input logic rnd);
    bus.i_CPHA          = cpha;
    bus.i_lsb_first     = lsb;
    bus.i_counter_enable = 1'b1;
    for (int unsigned k = 0; k < DW; k++) begin
      if (!cpha) begin
        bus.i_shift_enable = 1'b1;
        bus.i_miso = bit_at(slave, k, lsb);
        check("mosi_bit", 32'(bus.o_mosi), 32'(bit_at(tx, k, lsb)));
        check("cnt_done", 32'(bus.o_counter_done), 32'(k == DW - 1));
        pulse(1'b1, 1'b0);
        gap(rnd);
        if (glitch && k == 3) pulse(1'b1, 1'b1);
        pulse(1'b0, 1'b1);
      end else begin
        bus.i_shift_enable = (k != 0);
        pulse(1'b1, 1'b0);
        bus.i_shift_enable = 1'b1;
        bus.i_miso = bit_at(slave, k, lsb);
        gap(rnd);
        if (glitch && k == 3) pulse(1'b1, 1'b1);
        check("mosi_bit", 32'(bus.o_mosi), 32'(bit_at(tx, k, lsb)));
        check("cnt_done", 32'(bus.o_counter_done), 32'(k == DW - 1));
        pulse(1'b0, 1'b1);
      end
      if (k != DW - 1) begin
        check("rx_valid_low", 32'(bus.o_rx_valid), 32'd0);
        gap(rnd);
      end
    end
    check("rx_valid_pulse", 32'(bus.o_rx_valid), 32'd1);
    check("rx_data", 32'(bus.o_rx_data), 32'(exp_rx));
    bus.i_shift_enable   = 1'b0;
    bus.i_counter_enable = 1'b0;
    check("cnt_wrapped", 32'(bus.o_counter_done), 32'd0);
    tick();
    check("rx_valid_once", 32'(bus.o_rx_valid), 32'd0);
    check("rx_data_hold", 32'(bus.o_rx_data), 32'(exp_rx));
  endtask

  vec_t vecs[7];

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.i_load_register  = 1'b0;
    bus.i_shift_enable   = 1'b0;
    bus.i_counter_enable = 1'b0;
    bus.i_leading        = 1'b0;
    bus.i_trailling      = 1'b0;
    bus.i_CPHA           = 1'b0;
    bus.i_lsb_first      = 1'b0;
    bus.i_tx_data        = '0;
    bus.i_miso           = 1'b0;

    vecs[0] = '{tx: 8'hA5, slave: 8'h3C, cpha: 1'b0, lsb: 1'b0, exp_first: 1'b1, exp_rx: 8'h3C};
    vecs[1] = '{tx: 8'h81, slave: 8'hF0, cpha: 1'b1, lsb: 1'b1, exp_first: 1'b1, exp_rx: 8'hF0};
    vecs[2] = '{tx: 8'h55, slave: 8'h55, cpha: 1'b0, lsb: 1'b0, exp_first: 1'b0, exp_rx: 8'h55};
    vecs[3] = '{tx: 8'hAA, slave: 8'hAA, cpha: 1'b0, lsb: 1'b0, exp_first: 1'b1, exp_rx: 8'hAA};
    vecs[4] = '{tx: 8'h0F, slave: 8'hE7, cpha: 1'b0, lsb: 1'b1, exp_first: 1'b1, exp_rx: 8'hE7};
    vecs[5] = '{tx: 8'hF0, slave: 8'h01, cpha: 1'b1, lsb: 1'b0, exp_first: 1'b1, exp_rx: 8'h01};
    vecs[6] = '{tx: 8'h02, slave: 8'h80, cpha: 1'b1, lsb: 1'b1, exp_first: 1'b0, exp_rx: 8'h80};

    tick();
    tick();
    check("rst_mosi", 32'(bus.o_mosi), 32'd0);
    check("rst_rx_data", 32'(bus.o_rx_data), 32'd0);
    check("rst_rx_valid", 32'(bus.o_rx_valid), 32'd0);
    check("rst_cnt_done", 32'(bus.o_counter_done), 32'd0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      bus.i_CPHA            = vecs[i].cpha;
      bus.i_lsb_first       = vecs[i].lsb;
      bus.i_tx_data         = vecs[i].tx;
      bus.i_load_register   = 1'b1;
      tick();
      bus.i_load_register   = 1'b0;
      check("vec_first_bit", 32'(bus.o_mosi), 32'(vecs[i].exp_first));
      run_bits(vecs[i].tx, vecs[i].slave, vecs[i].exp_rx, vecs[i].cpha, vecs[i].lsb, 1'b0, 1'b0);
    end

    // Reset in the middle of a word: everything clears at once, partial word discarded.
    load_word(8'h3C, 1'b0, 1'b0);
    bus.i_shift_enable   = 1'b1;
    bus.i_counter_enable = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      bus.i_miso = 1'b1;
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_mosi", 32'(bus.o_mosi), 32'd0);
    check("midrst_rx_data", 32'(bus.o_rx_data), 32'd0);
    check("midrst_rx_valid", 32'(bus.o_rx_valid), 32'd0);
    check("midrst_cnt_done", 32'(bus.o_counter_done), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int unsigned k = 0; k < DW - 3; k++) begin
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
      check("postrst_no_valid", 32'(bus.o_rx_valid), 32'd0);
    end
    check("postrst_rx_data", 32'(bus.o_rx_data), 32'd0);
    bus.i_shift_enable   = 1'b0;
    bus.i_counter_enable = 1'b0;
    tick();

    // Load coinciding with a trailing edge mid-word: load wins, counter restarts.
    load_word(8'h12, 1'b0, 1'b0);
    bus.i_shift_enable   = 1'b1;
    bus.i_counter_enable = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
    end
    bus.i_tx_data         = 8'hC3;
    bus.i_load_register   = 1'b1;
    bus.i_trailling       = 1'b1;
    tick();
    bus.i_load_register   = 1'b0;
    bus.i_trailling       = 1'b0;
    check("ldprio_mosi", 32'(bus.o_mosi), 32'd1);
    check("ldprio_cnt_done", 32'(bus.o_counter_done), 32'd0);
    check("ldprio_no_valid", 32'(bus.o_rx_valid), 32'd0);
    run_bits(8'hC3, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized words with random gaps and occasional coincident strobes.
    for (int unsigned n = 0; n < 24; n++) begin
      logic [DW-1:0] tx;
      logic [DW-1:0] sl;
      logic          cpha;
      logic          lsb;
      logic          gl;
      tx   = DW'($urandom);
      sl   = DW'($urandom);
      cpha = 1'($urandom);
      lsb  = 1'($urandom);
      gl   = 1'($urandom);
      load_word(tx, cpha, lsb);
      gap(1'b1);
      run_bits(tx, sl, sl, cpha, lsb, gl, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
